// File: rtl/dds_scan_ctrl.sv
// dds_scan_ctrl: double-buffered dds_sin configurator driving out_en through active/blank scan windows.
// Define DDS_SCAN_FREQ_STEP_EN to step freq_sin by cfg_freq_step at each LOAD without pending config.
module dds_scan_ctrl #(
  parameter logic [31:0] PHASE_ACC_MAX = 32'd20000000,
  parameter int          DDS_LAT       = 4,
  parameter int          CNT_W         = 32
) (
  input  logic             clk_dds,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_wr,
  input  logic [31:0]      cfg_freq,
  input  logic [31:0]      cfg_phase,
  input  logic [15:0]      cfg_amp,
  input  logic [31:0]      cfg_freq_step,
  input  logic [CNT_W-1:0] cfg_active,
  input  logic [CNT_W-1:0] cfg_blank,
  input  logic [CNT_W-1:0] cfg_nscans,
  output logic [31:0]      freq_sin,
  output logic [31:0]      phase_sin_init,
  output logic [15:0]      amp_sin,
  output logic             out_en,
  output logic             data_valid,
  output logic             scan_sync,
  output logic             cfg_pend,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] scan_cnt
);
  typedef enum logic [1:0] {IDLE, LOAD, ACTIVE, BLANK} state_t;
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [31:0]      FMAX = PHASE_ACC_MAX - 32'd1;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, act_q, act_d, blank_q, blank_d, nscans_q, nscans_d, scan_cnt_q, scan_cnt_d;
  logic [31:0] sh_freq_q, sh_freq_d, sh_phase_q, sh_phase_d, freq_q, freq_d, phase_q, phase_d;
  logic [15:0] sh_amp_q, sh_amp_d, amp_q, amp_d;
  logic pend_q, pend_d, done_q, done_d;
  logic [DDS_LAT-1:0] dv_q;
  logic [DDS_LAT:0] dv_sh;
`ifdef DDS_SCAN_FREQ_STEP_EN
  logic [31:0] sh_step_q, sh_step_d;
  logic [32:0] fsum;
`else
  logic unused_step;
  assign unused_step = ^cfg_freq_step;
`endif

  assign out_en         = state_q == ACTIVE;
  assign scan_sync      = out_en && cnt_q == '0;
  assign busy           = state_q != IDLE;
  assign done           = done_q;
  assign cfg_pend       = pend_q;
  assign scan_cnt       = scan_cnt_q;
  assign freq_sin       = freq_q;
  assign phase_sin_init = phase_q;
  assign amp_sin        = amp_q;
  assign dv_sh          = {dv_q, out_en};
  assign data_valid     = dv_q[DDS_LAT-1];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    act_d      = act_q;
    blank_d    = blank_q;
    nscans_d   = nscans_q;
    scan_cnt_d = scan_cnt_q;
    sh_freq_d  = sh_freq_q;
    sh_phase_d = sh_phase_q;
    sh_amp_d   = sh_amp_q;
    freq_d     = freq_q;
    phase_d    = phase_q;
    amp_d      = amp_q;
    done_d     = 1'b0;
`ifdef DDS_SCAN_FREQ_STEP_EN
    sh_step_d  = sh_step_q;
    fsum       = {1'b0, freq_q} + {1'b0, sh_step_q};
`endif
    case (state_q)
      IDLE: if (start && !stop) begin
        state_d    = LOAD;
        scan_cnt_d = '0;
        act_d      = cfg_active == '0 ? ONE : cfg_active;
        blank_d    = cfg_blank;
        nscans_d   = cfg_nscans;
      end
      LOAD: begin
        state_d = ACTIVE;
        cnt_d   = '0;
      end
      ACTIVE: begin
        cnt_d = cnt_q + ONE;
        if (cnt_q == act_q - ONE) begin
          cnt_d      = '0;
          scan_cnt_d = &scan_cnt_q ? scan_cnt_q : scan_cnt_q + ONE;
          done_d     = nscans_q != '0 && scan_cnt_q == nscans_q - ONE;
          state_d    = done_d ? IDLE : blank_q != '0 ? BLANK : LOAD;
        end
      end
      default: begin
        cnt_d   = cnt_q + ONE;
        state_d = cnt_q == blank_q - ONE ? LOAD : BLANK;
      end
    endcase
    if (stop && state_q != IDLE) begin
      state_d    = IDLE;
      cnt_d      = cnt_q;
      scan_cnt_d = scan_cnt_q;
      done_d     = 1'b0;
    end
    // Live registers change on entry to LOAD so they settle a full cycle before out_en rises
    if (state_d == LOAD) begin
      if (pend_q) begin
        freq_d  = sh_freq_q;
        phase_d = sh_phase_q;
        amp_d   = sh_amp_q;
      end
`ifdef DDS_SCAN_FREQ_STEP_EN
      else freq_d = fsum >= {1'b0, FMAX} ? FMAX : fsum[31:0];
`endif
    end
    pend_d = cfg_wr | (pend_q & (state_d != LOAD));
    if (cfg_wr) begin
      sh_freq_d  = cfg_freq;
      sh_phase_d = cfg_phase >= PHASE_ACC_MAX ? cfg_phase - PHASE_ACC_MAX : cfg_phase;
      sh_amp_d   = cfg_amp;
`ifdef DDS_SCAN_FREQ_STEP_EN
      sh_step_d  = cfg_freq_step;
`endif
    end
  end

  always_ff @(posedge clk_dds or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      act_q      <= '0;
      blank_q    <= '0;
      nscans_q   <= '0;
      scan_cnt_q <= '0;
      sh_freq_q  <= '0;
      sh_phase_q <= '0;
      sh_amp_q   <= '0;
      freq_q     <= '0;
      phase_q    <= '0;
      amp_q      <= '0;
      pend_q     <= 1'b0;
      done_q     <= 1'b0;
      dv_q       <= '0;
`ifdef DDS_SCAN_FREQ_STEP_EN
      sh_step_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      act_q      <= act_d;
      blank_q    <= blank_d;
      nscans_q   <= nscans_d;
      scan_cnt_q <= scan_cnt_d;
      sh_freq_q  <= sh_freq_d;
      sh_phase_q <= sh_phase_d;
      sh_amp_q   <= sh_amp_d;
      freq_q     <= freq_d;
      phase_q    <= phase_d;
      amp_q      <= amp_d;
      pend_q     <= pend_d;
      done_q     <= done_d;
      dv_q       <= dv_sh[DDS_LAT-1:0];
`ifdef DDS_SCAN_FREQ_STEP_EN
      sh_step_q  <= sh_step_d;
`endif
    end
  end
endmodule

// File: tb/tb_dds_scan_ctrl.sv
// tb_dds_scan_ctrl: randomized scan runs checked against a per-cycle expected-waveform model.
module tb_dds_scan_ctrl;
  localparam logic [31:0] M = 32'd20000000;
  logic clk_dds = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0, cfg_wr = 1'b0;
  logic [31:0] cfg_freq = '0, cfg_phase = '0, cfg_freq_step = '0;
  logic [31:0] cfg_active = '0, cfg_blank = '0, cfg_nscans = '0;
  logic [15:0] cfg_amp = '0;
  logic [31:0] freq_sin, phase_sin_init, scan_cnt;
  logic [15:0] amp_sin;
  logic out_en, data_valid, scan_sync, cfg_pend, busy, done;
  int checks = 0, errors = 0;
  logic [31:0] m_sf, m_sp, m_f, m_p, m_step;
  logic [15:0] m_sa, m_a;
  logic m_pend;
  typedef struct packed {logic [4:0] c; logic [31:0] sc;} ev_t;

  dds_scan_ctrl dut (
    .clk_dds(clk_dds), .rst_n(rst_n), .start(start), .stop(stop), .cfg_wr(cfg_wr),
    .cfg_freq(cfg_freq), .cfg_phase(cfg_phase), .cfg_amp(cfg_amp), .cfg_freq_step(cfg_freq_step),
    .cfg_active(cfg_active), .cfg_blank(cfg_blank), .cfg_nscans(cfg_nscans),
    .freq_sin(freq_sin), .phase_sin_init(phase_sin_init), .amp_sin(amp_sin), .out_en(out_en),
    .data_valid(data_valid), .scan_sync(scan_sync), .cfg_pend(cfg_pend), .busy(busy),
    .done(done), .scan_cnt(scan_cnt)
  );

  always #5 clk_dds = ~clk_dds;

  task automatic tick;
    @(posedge clk_dds);
    #1;
  endtask

  function automatic ev_t mk(input logic [4:0] c, input logic [31:0] sc);
    ev_t e;
    e.c  = c;
    e.sc = sc;
    return e;
  endfunction

  task automatic model_clear;
    {m_sf, m_sp, m_f, m_p, m_step, m_sa, m_a, m_pend} = '0;
  endtask

  task automatic cfg_write(input logic [31:0] f, p, input logic [15:0] a, input logic [31:0] st);
    cfg_freq = f; cfg_phase = p; cfg_amp = a; cfg_freq_step = st; cfg_wr = 1'b1;
    tick;
    cfg_wr = 1'b0;
    m_sf = f; m_sp = p % M; m_sa = a; m_step = st; m_pend = 1'b1;
  endtask

  // Expected per-cycle stream c = {load, out_en, scan_sync, done, busy} built from scan geometry
  task automatic run_check(input int act, blk, n, stop_at, wr_at, input logic [31:0] wr_f, input logic hold);
    ev_t q[$];
    logic hist[$];
    logic wr_due;
    ev_t e;
    int a;
    longint t;
    logic [4:0] got, exp;
    a = act == 0 ? 1 : act;
    wr_due = 1'b0;
    for (int s = 0; (n == 0) ? (q.size() <= stop_at) : (s < n); s++) begin
      q.push_back(mk(5'b10001, 32'(s)));
      for (int i = 0; i < a; i++) q.push_back(mk({2'b01, i == 0, 2'b01}, 32'(s)));
      if (n != 0 && s == n - 1) q.push_back(mk(5'b00010, 32'(s + 1)));
      else for (int j = 0; j < blk; j++) q.push_back(mk(5'b00001, 32'(s + 1)));
    end
    if (stop_at >= 0) while (q.size() > stop_at + 1) void'(q.pop_back());
    e = q[q.size() - 1];
    repeat (6) q.push_back(mk(5'b00000, e.sc));
    hist = '{1'b0, 1'b0, 1'b0, 1'b0};
    cfg_active = 32'(act); cfg_blank = 32'(blk); cfg_nscans = 32'(n); start = 1'b1;
    tick;
    start = 1'b0; cfg_active = $urandom; cfg_blank = $urandom; cfg_nscans = $urandom;
    for (int i = 0; i < q.size(); i++) begin
      e = q[i];
      if (e.c[4]) begin
        if (m_pend) begin
          m_f = m_sf; m_p = m_sp; m_a = m_sa; m_pend = 1'b0;
        end
`ifdef DDS_SCAN_FREQ_STEP_EN
        else begin
          t = longint'(m_f) + longint'(m_step);
          m_f = t > longint'(M) - 1 ? M - 32'd1 : 32'(t);
        end
`endif
      end
      if (wr_due) begin
        m_sf = wr_f; m_pend = 1'b1; wr_due = 1'b0;
      end
      exp = {e.c[3:0], hist[hist.size() - 4]};
      got = {out_en, scan_sync, done, busy, data_valid};
      hist.push_back(e.c[3]);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL run obs %0d ctl(en,sync,done,busy,dv) got %b exp %b", i, got, exp);
      end
      checks++;
      if (scan_cnt !== e.sc) begin
        errors++;
        $display("FAIL run obs %0d scan_cnt got %0d exp %0d", i, scan_cnt, e.sc);
      end
      checks++;
      if ({freq_sin, phase_sin_init, amp_sin} !== {m_f, m_p, m_a}) begin
        errors++;
        $display("FAIL run obs %0d live f/p/a got %0d/%0d/%h exp %0d/%0d/%h", i,
                 freq_sin, phase_sin_init, amp_sin, m_f, m_p, m_a);
      end
      checks++;
      if (cfg_pend !== m_pend) begin
        errors++;
        $display("FAIL run obs %0d cfg_pend got %b exp %b", i, cfg_pend, m_pend);
      end
      start = hold & e.c[0];
      stop = i == stop_at;
      cfg_wr = i == wr_at;
      if (cfg_wr) begin
        cfg_freq = wr_f; cfg_phase = m_sp; cfg_amp = m_sa; cfg_freq_step = m_step; wr_due = 1'b1;
      end
      tick;
      cfg_wr = 1'b0; stop = 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick;
    tick;
    checks++;
    if ({out_en, data_valid, scan_sync, cfg_pend, busy, done, scan_cnt, freq_sin, phase_sin_init, amp_sin} !== '0) begin
      errors++;
      $display("FAIL reset outputs en=%b dv=%b sync=%b pend=%b busy=%b done=%b cnt=%0d f=%0d p=%0d a=%h exp all 0",
               out_en, data_valid, scan_sync, cfg_pend, busy, done, scan_cnt, freq_sin, phase_sin_init, amp_sin);
    end
    rst_n = 1'b1;
    tick;
    model_clear;
  endtask

  task automatic test_async_reset;
    cfg_write(32'd777, 32'd5, 16'h55, 32'd3);
    cfg_active = 32'd8; cfg_blank = 32'd2; cfg_nscans = 32'd0; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (6) tick;
    checks++;
    if ({out_en, data_valid} !== 2'b11) begin
      errors++;
      $display("FAIL async_reset pre en,dv got %b exp 11", {out_en, data_valid});
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_en, data_valid, scan_sync, cfg_pend, busy, done, scan_cnt, freq_sin, phase_sin_init, amp_sin} !== '0) begin
      errors++;
      $display("FAIL async_reset outputs en=%b dv=%b sync=%b pend=%b busy=%b done=%b cnt=%0d f=%0d p=%0d a=%h exp all 0",
               out_en, data_valid, scan_sync, cfg_pend, busy, done, scan_cnt, freq_sin, phase_sin_init, amp_sin);
    end
    tick;
    rst_n = 1'b1;
    tick;
    model_clear;
  endtask

  task automatic test_basic_run;
    cfg_write(32'd1000, 32'd0, 16'h4000, 32'd0);
    run_check(10, 5, 3, -1, -1, 32'd0, 1'b0);
    checks++;
    if ({scan_cnt, freq_sin, amp_sin} !== {32'd3, 32'd1000, 16'h4000}) begin
      errors++;
      $display("FAIL basic final cnt/f/a got %0d/%0d/%h exp 3/1000/4000", scan_cnt, freq_sin, amp_sin);
    end
  endtask

  task automatic test_phase_wrap;
    cfg_write(32'd1500, 32'd20000005, 16'h1234, 32'd0);
    run_check(3, 0, 2, -1, -1, 32'd0, 1'b0);
    checks++;
    if (phase_sin_init !== 32'd5) begin
      errors++;
      $display("FAIL phase_wrap phase_sin_init got %0d exp 5", phase_sin_init);
    end
  endtask

  task automatic test_mid_scan_cfg;
    cfg_write(32'd1000, 32'd0, 16'h4000, 32'd0);
    run_check(10, 5, 3, -1, 5, 32'd2000, 1'b0);
    checks++;
    if ({freq_sin, cfg_pend} !== {32'd2000, 1'b0}) begin
      errors++;
      $display("FAIL mid_cfg final f/pend got %0d/%b exp 2000/0", freq_sin, cfg_pend);
    end
  endtask

  task automatic test_stop_resume;
    run_check(10, 5, 0, 28, 27, 32'd3000, 1'b0);
    checks++;
    if ({busy, done, cfg_pend} !== 3'b001) begin
      errors++;
      $display("FAIL stop busy/done/pend got %b exp 001", {busy, done, cfg_pend});
    end
    run_check(4, 2, 2, -1, -1, 32'd0, 1'b0);
  endtask

  task automatic test_start_stop_idle;
    start = 1'b1; stop = 1'b1;
    repeat (3) begin
      tick;
      checks++;
      if ({busy, out_en} !== 2'b00) begin
        errors++;
        $display("FAIL start_stop_idle busy/en got %b exp 00", {busy, out_en});
      end
    end
    start = 1'b0; stop = 1'b0;
    repeat (2) tick;
  endtask

  task automatic test_random;
    int act, blk, n, len, stop_at, wr_at;
    for (int k = 0; k < 10; k++) begin
      if ($urandom_range(0, 1) == 1)
        cfg_write($urandom_range(0, M - 1), $urandom_range(0, 2 * M - 1), 16'($urandom), $urandom_range(0, 1000));
      act = $urandom_range(0, 6);
      blk = $urandom_range(0, 4);
      n = $urandom_range(1, 3);
      len = n * (1 + (act == 0 ? 1 : act)) + (n - 1) * blk;
      stop_at = $urandom_range(0, 2) == 0 ? $urandom_range(0, len - 1) : -1;
      wr_at = $urandom_range(0, 1) == 1 ? $urandom_range(0, stop_at >= 0 ? stop_at : len) : -1;
      run_check(act, blk, n, stop_at, wr_at, $urandom_range(0, M - 1), 1'($urandom_range(0, 1)));
    end
  endtask

`ifdef DDS_SCAN_FREQ_STEP_EN
  task automatic test_freq_step;
    cfg_write(32'd19999990, 32'd0, 16'h0100, 32'd8);
    run_check(2, 1, 3, -1, -1, 32'd0, 1'b0);
    checks++;
    if (freq_sin !== 32'd19999999) begin
      errors++;
      $display("FAIL freq_step final freq got %0d exp 19999999", freq_sin);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_async_reset;
    test_basic_run;
    test_phase_wrap;
    test_mid_scan_cfg;
    test_stop_resume;
    test_start_stop_idle;
    test_random;
`ifdef DDS_SCAN_FREQ_STEP_EN
    test_freq_step;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dds_scan_ctrl.md
Name: dds_scan_ctrl

Overview:
Sequencer/configurator for the dds_sin modulation generator in the TDLAS chain. Holds double-buffered sine settings (frequency, initial phase, amplitude), applies them only at scan boundaries, and drives out_en through repeated active/blank scan windows. Produces a scan-sync pulse and a data_valid flag aligned to the DDS output pipeline for the downstream ADC/lock-in logic.

Parameters:
PHASE_ACC_MAX, 32'd20000000, DDS phase wrap modulus; must match the DDS.
DDS_LAT, 4, cycles from out_en rising to first valid sin_out.
CNT_W, 32, width of active/blank/scan counters.

Ports:
clk_dds  in  1  DDS clock; sole clock.
rst_n  in  1  asynchronous, active-low reset.
start  in  1  pulse; begin scanning (IDLE only).
stop  in  1  level/pulse; abort to IDLE.
cfg_wr  in  1  pulse; write cfg_* into shadow registers.
cfg_freq  in  32  frequency word.
cfg_phase  in  32  initial phase word.
cfg_amp  in  16  amplitude.
cfg_freq_step  in  32  per-scan frequency increment (optional feature).
cfg_active  in  CNT_W  active cycles per scan (0 treated as 1).
cfg_blank  in  CNT_W  blank cycles between scans (0 allowed).
cfg_nscans  in  CNT_W  scans per run; 0 = continuous.
freq_sin  out  32  to DDS.
phase_sin_init  out  32  to DDS.
amp_sin  out  16  to DDS.
out_en  out  1  to DDS.
data_valid  out  1  out_en delayed DDS_LAT cycles.
scan_sync  out  1  one-cycle pulse on first ACTIVE cycle of each scan.
cfg_pend  out  1  shadow holds unapplied data.
busy  out  1  state != IDLE.
done  out  1  one-cycle pulse on normal completion.
scan_cnt  out  CNT_W  completed scans in current run.

Behaviour:
- Reset: all outputs 0, shadows 0, state IDLE, data_valid pipeline cleared.
- cfg_wr: shadow <= cfg_*; cfg_pend <= 1. Phase reduced once: if cfg_phase >= PHASE_ACC_MAX store cfg_phase - PHASE_ACC_MAX (caller keeps < 2*PHASE_ACC_MAX). cfg_active/cfg_blank/cfg_nscans sampled into run registers at start only.
- States: IDLE, LOAD, ACTIVE, BLANK.
- IDLE: out_en=0. start && !stop -> LOAD; scan_cnt <= 0.
- LOAD (1 cycle, out_en=0): live outputs <= shadow if cfg_pend, cfg_pend <= 0; otherwise hold. Guarantees phase_sin_init stable >=1 cycle before out_en rises. -> ACTIVE.
- ACTIVE: out_en=1; counter runs 0..max(cfg_active,1)-1; scan_sync on count 0. At last count: scan_cnt++; if cfg_nscans!=0 && scan_cnt+1==cfg_nscans -> IDLE, done pulse; else blank!=0 -> BLANK, else -> LOAD.
- BLANK: out_en=0 for cfg_blank cycles, then -> LOAD.
- stop (any non-IDLE state, highest priority): next cycle IDLE, out_en=0, no done; live regs and cfg_pend retained.
- cfg_wr in same cycle as LOAD: not applied this scan; shadow updated, cfg_pend stays 1.
- start while busy: ignored. start && stop in IDLE: stays IDLE.
- data_valid: DDS_LAT-stage shift of out_en; cleared by reset, not by stop (pipeline drains).
- Counters never wrap silently: scan_cnt saturates at all-ones in continuous mode.

Optional Feature:
DDS_SCAN_FREQ_STEP_EN. Defined: in every LOAD without cfg_pend, freq_sin <= freq_sin + cfg_freq_step, saturating at PHASE_ACC_MAX-1 (stepped chirp across scans); LOAD with cfg_pend loads shadow freq instead. Undefined: cfg_freq_step ignored, freq_sin changes only via shadow.

Test Plan:
- Reset mid-ACTIVE (out_en=1) -> all outputs 0 asynchronously, state IDLE, data_valid 0 immediately.
- cfg_wr freq=1000, phase=0, amp=16'h4000; cfg_active=10, cfg_blank=5, cfg_nscans=3; start -> LOAD 1 cycle, out_en high 10 cycles, low 5, three scans, done pulse on cycle after last active, scan_cnt=3, data_valid trails out_en by 4.
- cfg_phase=20000005 written -> phase_sin_init=5 after next LOAD.
- cfg_wr freq=2000 mid-scan 1 -> freq_sin stays 1000 until scan 2 LOAD, then 2000; cfg_pend 1 then 0.
- stop during BLANK of scan 2 with cfg_nscans=0 -> IDLE next cycle, no done, busy 0; new start resumes with retained settings.
- With DDS_SCAN_FREQ_STEP_EN, freq=19999990, step=8, 3 scans -> freq_sin 19999990, 19999998, 19999999 (saturated).
